signal_debouncer: RTL and testbench



---
 rtl/signal_debouncer.sv | 168 ++++++++++++++++
 tb/tb_signal_debouncer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_debouncer.sv
// signal_debouncer: synchronises a raw, bouncy input into the clk domain and
// only lets the clean `signal` level change after the synchronised input has
// held one value for STABLE_CYCLES consecutive cycles. Aborted qualification
// attempts are counted in a saturating glitch counter.
module signal_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                signal,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int                CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX  = {GLITCH_W{1'b1}};
    localparam logic [GLITCH_W-1:0] GLITCH_ZERO = {GLITCH_W{1'b0}};
    localparam logic [GLITCH_W-1:0] GLITCH_ONE  = GLITCH_W'(1);
    // With a single-cycle qualification window the idle states commit directly.
    localparam logic              SINGLE_CYC = (STABLE_CYCLES == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_in_s;
    state_t                 state_r,  state_s;
    logic [CNT_W-1:0]       cnt_r,    cnt_s;
    logic                   signal_r, signal_s;
    logic                   busy_r,   busy_s;
    logic [GLITCH_W-1:0]    glitch_r, glitch_s;
    logic                   glitch_evt_s;

    // Synchroniser chain: raw_in enters at bit 0, the FSM only sees the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_in_s = sync_r[SYNC_STAGES-1];

    // FSM state, qualify counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE_LOW;
            cnt_r    <= CNT_ZERO;
            signal_r <= 1'b0;
            busy_r   <= 1'b0;
            glitch_r <= GLITCH_ZERO;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            signal_r <= signal_s;
            busy_r   <= busy_s;
            glitch_r <= glitch_s;
        end
    end

    // Next-state logic: qualify a candidate level, abort on any disagreeing sample.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        signal_s     = signal_r;
        busy_s       = busy_r;
        glitch_evt_s = 1'b0;
        case (state_r)
            IDLE_LOW: begin
                if (sync_in_s) begin
                    if (SINGLE_CYC) begin
                        state_s  = IDLE_HIGH;
                        signal_s = 1'b1;
                    end else begin
                        state_s = WAIT_HIGH;
                        cnt_s   = CNT_ONE;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (sync_in_s) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s  = IDLE_HIGH;
                        signal_s = 1'b1;
                        busy_s   = 1'b0;
                        cnt_s    = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s      = IDLE_LOW;
                    busy_s       = 1'b0;
                    cnt_s        = CNT_ZERO;
                    glitch_evt_s = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync_in_s) begin
                    if (SINGLE_CYC) begin
                        state_s  = IDLE_LOW;
                        signal_s = 1'b0;
                    end else begin
                        state_s = WAIT_LOW;
                        cnt_s   = CNT_ONE;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE_HIGH;
                end
            end
            WAIT_LOW: begin
                if (!sync_in_s) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s  = IDLE_LOW;
                        signal_s = 1'b0;
                        busy_s   = 1'b0;
                        cnt_s    = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s      = IDLE_HIGH;
                    busy_s       = 1'b0;
                    cnt_s        = CNT_ZERO;
                    glitch_evt_s = 1'b1;
                end
            end
            default: begin
                state_s  = IDLE_LOW;
                cnt_s    = CNT_ZERO;
                signal_s = 1'b0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // Glitch counter: clear has priority over a same-edge event; saturates at max.
    always_comb begin
        glitch_s = glitch_r;
        if (glitch_clr) begin
            glitch_s = GLITCH_ZERO;
        end else if (glitch_evt_s && (glitch_r != GLITCH_MAX)) begin
            glitch_s = glitch_r + GLITCH_ONE;
        end else begin
            glitch_s = glitch_r;
        end
    end

    assign signal     = signal_r;
    assign busy       = busy_r;
    assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_signal_debouncer.sv
// tb_signal_debouncer: directed checks of the debouncer with default parameters,
// with STABLE_CYCLES=1, and with a 2-bit glitch counter.
module tb_signal_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_a, raw_b, raw_c;
    logic       clr_a, clr_b, clr_c;
    logic       signal_a, signal_b, signal_c;
    logic       busy_a, busy_b, busy_c;
    logic [7:0] glitch_a, glitch_b;
    logic [1:0] glitch_c;

    int vectors = 0;
    int errors  = 0;
    int edges_a = 0;

    // 20 ns clock.
    always #10 clk = ~clk;

    // Count every level change of the default instance's output (downstream edges).
    always @(signal_a) edges_a = edges_a + 1;

    signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .GLITCH_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_a), .glitch_clr(clr_a),
        .signal(signal_a), .busy(busy_a), .glitch_cnt(glitch_a));

    signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_b), .glitch_clr(clr_b),
        .signal(signal_b), .busy(busy_b), .glitch_cnt(glitch_b));

    signal_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .GLITCH_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_c), .glitch_clr(clr_c),
        .signal(signal_c), .busy(busy_c), .glitch_cnt(glitch_c));

    // Reference waveform for the full-cycle test (in clock cycles).
    function automatic logic wave(input int m);
        if (m < 0)        return 1'b0;
        else if (m < 125) return 1'b1;
        else if (m < 250) return 1'b0;
        else if (m < 500) return 1'b1;
        else              return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        raw_a = 1'b0; raw_b = 1'b0; raw_c = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        #50;
        vectors++;
        if (signal_a !== 1'b0 || busy_a !== 1'b0 || glitch_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold: got signal=%b busy=%b glitch=%0d expected 0/0/0", signal_a, busy_a, glitch_a);
        end
        vectors++;
        if (signal_b !== 1'b0 || signal_c !== 1'b0 || glitch_c !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold_bc: got signal_b=%b signal_c=%b glitch_c=%0d expected 0/0/0", signal_b, signal_c, glitch_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (signal_a !== 1'b0 || busy_a !== 1'b0 || glitch_a !== 8'd0) begin
                errors++;
                $display("FAIL reset_settle[%0d]: got signal=%b busy=%b glitch=%0d expected 0/0/0", i, signal_a, busy_a, glitch_a);
            end
        end
    endtask

    task automatic test_clean_edges();
        logic exp_sig, exp_busy;
        // Rise: raw set before edge 0, signal updates on edge 9 (10th edge).
        for (int m = 0; m <= 12; m++) begin
            @(negedge clk);
            exp_sig  = (m >= 10);
            exp_busy = (m >= 3 && m <= 9);
            vectors++;
            if (signal_a !== exp_sig || busy_a !== exp_busy) begin
                errors++;
                $display("FAIL clean_rise[%0d]: got signal=%b busy=%b expected %b/%b", m, signal_a, busy_a, exp_sig, exp_busy);
            end
            if (m == 0) raw_a = 1'b1;
        end
        // Fall: mirror image.
        for (int m = 0; m <= 12; m++) begin
            @(negedge clk);
            exp_sig  = (m < 10);
            exp_busy = (m >= 3 && m <= 9);
            vectors++;
            if (signal_a !== exp_sig || busy_a !== exp_busy) begin
                errors++;
                $display("FAIL clean_fall[%0d]: got signal=%b busy=%b expected %b/%b", m, signal_a, busy_a, exp_sig, exp_busy);
            end
            if (m == 0) raw_a = 1'b0;
        end
        vectors++;
        if (glitch_a !== 8'd0) begin
            errors++;
            $display("FAIL clean_glitch: got %0d expected 0", glitch_a);
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        logic        exp_sig;
        int          base;
        pat  = 12'b1100_1100_1100;
        base = edges_a;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (signal_a !== 1'b0) begin
                errors++;
                $display("FAIL bounce_hold[%0d]: got %b expected 0", i, signal_a);
            end
            raw_a = pat[11-i];
        end
        for (int m = 0; m <= 12; m++) begin
            @(negedge clk);
            exp_sig = (m >= 10);
            vectors++;
            if (signal_a !== exp_sig) begin
                errors++;
                $display("FAIL bounce_settle[%0d]: got %b expected %b", m, signal_a, exp_sig);
            end
            if (m == 0) raw_a = 1'b1;
        end
        vectors++;
        if (glitch_a !== 8'd3) begin
            errors++;
            $display("FAIL bounce_glitch: got %0d expected 3", glitch_a);
        end
        vectors++;
        if (edges_a - base !== 1) begin
            errors++;
            $display("FAIL bounce_edges: got %0d expected 1", edges_a - base);
        end
        // Return to low and clear the counter.
        raw_a = 1'b0;
        repeat (12) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        vectors++;
        if (signal_a !== 1'b0 || glitch_a !== 8'd0) begin
            errors++;
            $display("FAIL bounce_clear: got signal=%b glitch=%0d expected 0/0", signal_a, glitch_a);
        end
    endtask

    task automatic test_full_cycle();
        logic exp_sig;
        int   base;
        base = edges_a;
        for (int m = 0; m < 520; m++) begin
            @(negedge clk);
            exp_sig = wave(m - 10);
            vectors++;
            if (signal_a !== exp_sig) begin
                errors++;
                $display("FAIL full_cycle[%0d]: got %b expected %b", m, signal_a, exp_sig);
            end
            raw_a = wave(m);
        end
        vectors++;
        if (edges_a - base !== 4) begin
            errors++;
            $display("FAIL full_cycle_edges: got %0d expected 4", edges_a - base);
        end
        vectors++;
        if (glitch_a !== 8'd0) begin
            errors++;
            $display("FAIL full_cycle_glitch: got %0d expected 0", glitch_a);
        end
    endtask

    task automatic test_reset_mid_run();
        raw_a = 1'b1;
        repeat (12) @(negedge clk);
        raw_a = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (signal_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: got signal=%b busy=%b expected 1/1", signal_a, busy_a);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (signal_a !== 1'b0 || busy_a !== 1'b0 || glitch_a !== 8'd0) begin
            errors++;
            $display("FAIL midrun_async: got signal=%b busy=%b glitch=%0d expected 0/0/0", signal_a, busy_a, glitch_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (signal_a !== 1'b0 || busy_a !== 1'b0 || glitch_a !== 8'd0) begin
            errors++;
            $display("FAIL midrun_after: got signal=%b busy=%b glitch=%0d expected 0/0/0", signal_a, busy_a, glitch_a);
        end
    endtask

    task automatic test_stable_one();
        logic exp_sig;
        for (int m = 0; m <= 6; m++) begin
            @(negedge clk);
            exp_sig = (m == 3);
            vectors++;
            if (signal_b !== exp_sig || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL stable1[%0d]: got signal=%b busy=%b expected %b/0", m, signal_b, busy_b, exp_sig);
            end
            raw_b = (m == 0);
        end
        vectors++;
        if (glitch_b !== 8'd0) begin
            errors++;
            $display("FAIL stable1_glitch: got %0d expected 0", glitch_b);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_g;
        for (int g = 1; g <= 6; g++) begin
            for (int p = 0; p < 4; p++) begin
                @(negedge clk);
                raw_c = (p == 0);
                clr_c = (g == 6 && p == 3);
            end
            @(negedge clk);
            clr_c = 1'b0;
            exp_g = (g == 6) ? 2'd0 : ((g >= 3) ? 2'd3 : 2'(g));
            vectors++;
            if (glitch_c !== exp_g || signal_c !== 1'b0) begin
                errors++;
                $display("FAIL saturate[%0d]: got glitch=%0d signal=%b expected %0d/0", g, glitch_c, signal_c, exp_g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_edges();
        test_bounce();
        test_full_cycle();
        test_reset_mid_run();
        test_stable_one();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
